// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_muldiv execute-stage unit.
//   - 5-bit ALUCtrl operation codes
//   - sequencer state encoding (IDLE, MUL, DIV, DONE)
//   - HI/LO select constants used by mfhi/mflo
//   - is_iter_op(): true for ops that go through the iterative mult/div unit
package alu_pkg;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_NOR  = 5'b01000;
    localparam logic [4:0] OP_XOR  = 5'b01001;
    localparam logic [4:0] OP_SLL  = 5'b01010;
    localparam logic [4:0] OP_SRL  = 5'b10000;
    localparam logic [4:0] OP_SRA  = 5'b10001;
    localparam logic [4:0] OP_MULT = 5'b10010;
    localparam logic [4:0] OP_DIV  = 5'b10011;
    localparam logic [4:0] OP_MFHI = 5'b10100;
    localparam logic [4:0] OP_MFLO = 5'b10101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    function automatic logic is_iter_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative multiply / divide engine.
//   Multiply is shift-add on operand magnitudes, divide is restoring division
//   on magnitudes; signs are fixed up on the way out.
// Ports:
//   clk, reset      clock, synchronous active-high reset (aborts an op)
//   start           load operands and begin (one-cycle strobe)
//   is_div          1 = divide, 0 = multiply (sampled with start)
//   sign            1 = signed operands (sampled with start)
//   a, b            dividend/multiplicand, divisor/multiplier
//   done            combinational strobe: {hi, lo} valid in this cycle
//   hi, lo          result halves (remainder/quotient for divide)
// Config macro ALU_EARLY_TERM_EN: multiply stops once the remaining
//   multiplier bits are all zero (at least one iteration).
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic               running;
    logic               div_mode;
    logic               prod_neg;
    logic               quo_neg;
    logic               rem_neg;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic               mul_done;

    assign mag_a = (sign && a[WIDTH-1]) ? -a : a;
    assign mag_b = (sign && b[WIDTH-1]) ? -b : b;

    // One iteration step for both algorithms. The multiply step is a no-op
    // once the multiplier is exhausted, so the early-exit cycle can reuse
    // prod_nxt as the final product without a special case.
    always_comb begin
        prod_nxt = prod;
        if (mplier[0]) begin
            prod_nxt = prod + mcand;
        end
        trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};
        if (trial[WIDTH]) begin
            rem_nxt = {rem[WIDTH-2:0], quo[WIDTH-1]};
        end else begin
            rem_nxt = trial[WIDTH-1:0];
        end
        quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

    // Completion: divide always runs WIDTH steps; multiply either runs WIDTH
    // steps or, with early termination, leaves on the first cycle that finds
    // no multiplier bits left (never on the very first iteration).
`ifdef ALU_EARLY_TERM_EN
    assign mul_done = (count != '0) && (mplier == '0);
`else
    assign mul_done = (count == LAST);
`endif
    assign done = running && (div_mode ? (count == LAST) : mul_done);

    // Sign fix-up of the final step. A zero divisor leaves the quotient as
    // all ones and the remainder as the dividend, so the quotient is not
    // negated in that case; the remainder still takes the dividend's sign.
    assign prod_fix = prod_neg ? -prod_nxt : prod_nxt;
    assign hi = div_mode ? (rem_neg ? -rem_nxt : rem_nxt) : prod_fix[2*WIDTH-1:WIDTH];
    assign lo = div_mode ? (quo_neg ? -quo_nxt : quo_nxt) : prod_fix[WIDTH-1:0];

    // Operand load on start, then one step per cycle while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            running  <= 1'b0;
            div_mode <= 1'b0;
            prod_neg <= 1'b0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            count    <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
        end else if (start) begin
            running  <= 1'b1;
            div_mode <= is_div;
            prod_neg <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
            quo_neg  <= sign && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
            rem_neg  <= sign && a[WIDTH-1];
            count    <= '0;
            prod     <= '0;
            mcand    <= {{WIDTH{1'b0}}, mag_a};
            mplier   <= mag_b;
            rem      <= '0;
            quo      <= mag_a;
            divisor  <= mag_b;
        end else if (running) begin
            if (done) begin
                running <= 1'b0;
            end
            count  <= count + ONE;
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_nxt;
            quo    <= quo_nxt;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with iterative multiply/divide and HI/LO registers.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_valid        operation presented
//   in_ready        unit accepts an operation this cycle (state IDLE)
//   ALUCtrl         5-bit op code (see alu_pkg)
//   Sign            1 = signed slt/mult/div
//   in1, in2        operands; in1[SHW-1:0] is the shift amount
//   out_valid       one-cycle pulse, out/zero valid
//   out, zero       registered result and (out == 0)
//   busy            iterative op in flight
// Config macro ALU_EARLY_TERM_EN: early multiply termination in the
//   iterative unit; results are identical, only latency changes.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUCtrl,
    input  logic             Sign,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] alu_res;
    logic             lt;
    logic             hilo_sel;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign iter_start = in_ready && in_valid && is_iter_op(ALUCtrl);
    assign hilo_sel   = (ALUCtrl == OP_MFHI) ? SEL_HI : SEL_LO;

    // Single-cycle result. mult/div codes fall into the default here; their
    // result comes from the iterative unit instead.
    always_comb begin
        alu_res = '0;
        lt      = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);
        case (ALUCtrl)
            OP_AND:           alu_res = in1 & in2;
            OP_OR:            alu_res = in1 | in2;
            OP_ADD:           alu_res = in1 + in2;
            OP_SUB:           alu_res = in1 - in2;
            OP_SLT:           alu_res = {{(WIDTH-1){1'b0}}, lt};
            OP_NOR:           alu_res = ~(in1 | in2);
            OP_XOR:           alu_res = in1 ^ in2;
            OP_SLL:           alu_res = in2 << in1[SHW-1:0];
            OP_SRL:           alu_res = in2 >> in1[SHW-1:0];
            OP_SRA:           alu_res = $signed(in2) >>> in1[SHW-1:0];
            OP_MFHI, OP_MFLO: alu_res = (hilo_sel == SEL_HI) ? hi_reg : lo_reg;
            default:          alu_res = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (iter_start),
        .is_div (ALUCtrl == OP_DIV),
        .sign   (Sign),
        .a      (in1),
        .b      (in2),
        .done   (iter_done),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

    // Issue sequencer. Single-cycle ops complete in IDLE; mult/div park in
    // MUL/DIV until the engine strobes done, which writes HI/LO and the
    // result together so the DONE cycle is the out_valid cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hi_reg    <= '0;
            lo_reg    <= '0;
            out       <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (ALUCtrl == OP_MULT) begin
                            state <= MUL;
                        end else if (ALUCtrl == OP_DIV) begin
                            state <= DIV;
                        end else begin
                            out       <= alu_res;
                            zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    if (iter_done) begin
                        hi_reg    <= iter_hi;
                        lo_reg    <= iter_lo;
                        out       <= iter_lo;
                        zero      <= (iter_lo == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
